mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 25 ++
 rtl/mem_bus_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory bus arbiter:
// default bus widths and the controller state encoding.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 8;
    localparam int unsigned DATA_W_DEFAULT = 18;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_DATA,
        TURN
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: picks a one-hot winner when enabled and
// reports the updated last-granted pointer (held when nothing wins).
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       last,
    output logic [1:0] winner,
    output logic       next_last
);

    always_comb begin
        winner = '0;
        if (enable) begin
            case (req)
                2'b01:   winner = 2'b01;
                2'b10:   winner = 2'b10;
                // On a tie the requester not granted most recently wins.
                2'b11:   winner = last ? 2'b01 : 2'b10;
                default: winner = '0;
            endcase
        end
        next_last = (winner == '0) ? last : winner[1];
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates two requesters onto a single synchronous memory with a shared
// bidirectional data bus; reads insert a turnaround cycle before release.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_oe,
    output logic                  mem_rw,
    inout  wire  [DATA_W-1:0]     mem_data
);

    state_t              state;
    logic                last;
    logic                owner;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          winner;
    logic                next_last;
    logic                sel;
    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   wdata_sel;

    rr_arbiter2 u_arb (
        .req       (req),
        .enable    (state == IDLE),
        .last      (last),
        .winner    (winner),
        .next_last (next_last)
    );

    always_comb begin
        sel       = winner[1];
        addr_sel  = sel ? addr[2*ADDR_W-1:ADDR_W]   : addr[ADDR_W-1:0];
        wdata_sel = sel ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    end

    // mem_address doubles as the captured address; mem_rw as the captured we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            rvalid      <= '0;
            rdata       <= '0;
            mem_oe      <= 1'b0;
            mem_rw      <= 1'b0;
            mem_address <= '0;
            wdata_q     <= '0;
            last        <= 1'b1;
            owner       <= 1'b0;
        end else begin
            gnt    <= '0;
            rvalid <= '0;
            case (state)
                IDLE: begin
                    if (winner != '0) begin
                        gnt         <= winner;
                        owner       <= sel;
                        last        <= next_last;
                        mem_address <= addr_sel;
                        wdata_q     <= wdata_sel;
                        mem_oe      <= 1'b1;
                        mem_rw      <= we[sel];
                        state       <= we[sel] ? WRITE : RD_ADDR;
                    end
                end
                WRITE: begin
                    mem_oe <= 1'b0;
                    mem_rw <= 1'b0;
                    state  <= IDLE;
                end
                RD_ADDR: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    rdata  <= mem_data;
                    mem_oe <= 1'b0;
                    rvalid <= owner ? 2'b10 : 2'b01;
                    state  <= TURN;
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_data = (state == WRITE) ? wdata_q : 'z;

endmodule
